// File: rtl/btb_predictor_pkg.sv
// Shared types, counter encodings and the saturating-counter helper for btb_predictor.
// Build option: BPU_RAS_EN adds the return-address-stack ret bit to btb_entry_t.
package btb_predictor_pkg;

   localparam int unsigned BTB_DEF_PC  = 32;
   localparam int unsigned BTB_DEF_TAG = 26;

   localparam logic [1:0] CTR_WEAK_NT = 2'b01;
   localparam logic [1:0] CTR_WEAK_T  = 2'b10;

   // Entry layout for the default geometry (PC=32, ENTRIES=16).
   typedef struct packed {
      logic                   valid;
      logic [BTB_DEF_TAG-1:0] tag;
      logic [BTB_DEF_PC-1:0]  target;
      logic [1:0]             ctr;
`ifdef BPU_RAS_EN
      logic                   ret;
`endif
   } btb_entry_t;

   function automatic logic [1:0] ctr_sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/btb_predictor_ras_stack.sv
// Circular return-address stack; overflow overwrites the oldest entry, pop on empty is ignored.
// Instantiated by btb_predictor only when BPU_RAS_EN is defined.
module ras_stack #(
   parameter int unsigned PC        = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          push_in,
   input  logic          pop_in,
   input  logic [PC-1:0] push_data_in,
   output logic [PC-1:0] top_out,
   output logic          empty_out
);

   localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

   logic [PC-1:0]   mem_q [RAS_DEPTH];
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [PtrW-1:0] top_idx;

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push_in) begin
         ptr_d = ptr_q + PtrW'(1);
         if (cnt_q != CntW'(RAS_DEPTH)) begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else if (pop_in && (cnt_q != '0)) begin
         ptr_d = ptr_q - PtrW'(1);
         cnt_d = cnt_q - CntW'(1);
      end
   end

   // ptr_q names the next free slot, so the top sits one below it.
   assign top_idx   = ptr_q - PtrW'(1);
   assign top_out   = mem_q[top_idx];
   assign empty_out = (cnt_q == '0);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         ptr_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         if (push_in) begin
            mem_q[ptr_q] <= push_data_in;
         end
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters: same-cycle fetch prediction, EX/MEM training, restore PC.
// Build option: BPU_RAS_EN adds a return-address stack that overrides targets of predicted returns.
module btb_predictor
   import btb_predictor_pkg::*;
#(
   parameter int unsigned PC        = 32,
   parameter int unsigned ENTRIES   = 16,
   parameter int unsigned TAG       = PC - 2 - $clog2(ENTRIES),
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic [PC-1:0] fetch_pc_in,
   output logic          fetch_prediction_out,
   output logic [PC-1:0] pc_prediction_out,
   input  logic          update_valid_in,
   input  logic [PC-1:0] update_pc_in,
   input  logic          update_taken_in,
   input  logic [PC-1:0] update_target_in,
   input  logic          update_is_call_in,
   input  logic          update_is_ret_in,
   output logic [1:0]    update_confidence_out,
   output logic [PC-1:0] pc_restore_out,
   output logic          mispredict_out
);

   localparam int unsigned   IDX       = $clog2(ENTRIES);
   localparam logic [PC-1:0] InstBytes = PC'(4);

   logic [ENTRIES-1:0] valid_q;
   logic [TAG-1:0]     tag_q    [ENTRIES];
   logic [PC-1:0]      target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];

   logic [IDX-1:0] f_idx, u_idx;
   logic           f_hit, u_hit;
   logic           f_taken, u_pred_taken;
   logic [PC-1:0]  f_target, u_pred_target;
   logic           wr_en;
   logic [1:0]     ctr_d;

`ifdef BPU_RAS_EN
   logic [ENTRIES-1:0] ret_q;
   logic [PC-1:0]      ras_top;
   logic               ras_empty;
   logic               ras_push, ras_pop;

   assign ras_push = update_valid_in & update_is_call_in;
   assign ras_pop  = update_valid_in & update_is_ret_in & ~update_is_call_in;

   ras_stack #(
      .PC        (PC),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras_stack (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_in      (ras_push),
      .pop_in       (ras_pop),
      .push_data_in (update_pc_in + InstBytes),
      .top_out      (ras_top),
      .empty_out    (ras_empty)
   );
`else
   localparam int unsigned unused_ras_depth = RAS_DEPTH;
   logic unused_ras_flags;
   assign unused_ras_flags = update_is_call_in ^ update_is_ret_in;
`endif

   always_comb begin
      f_idx         = fetch_pc_in[IDX+1:2];
      u_idx         = update_pc_in[IDX+1:2];
      f_hit         = valid_q[f_idx] && (tag_q[f_idx] == fetch_pc_in[PC-1:IDX+2]);
      u_hit         = valid_q[u_idx] && (tag_q[u_idx] == update_pc_in[PC-1:IDX+2]);
      f_taken       = f_hit && ctr_q[f_idx][1];
      u_pred_taken  = u_hit && ctr_q[u_idx][1];
      f_target      = target_q[f_idx];
      u_pred_target = target_q[u_idx];
`ifdef BPU_RAS_EN
      if (ret_q[f_idx] && !ras_empty) begin
         f_target = ras_top;
      end
      if (ret_q[u_idx] && !ras_empty) begin
         u_pred_target = ras_top;
      end
`endif
   end

   assign fetch_prediction_out  = f_taken;
   assign pc_prediction_out     = f_taken ? f_target : fetch_pc_in + InstBytes;
   assign update_confidence_out = u_hit ? ctr_q[u_idx] : 2'b00;
   assign pc_restore_out        = update_taken_in ? update_target_in : update_pc_in + InstBytes;
   assign mispredict_out        = update_valid_in &
                                  ((u_pred_taken != update_taken_in) |
                                   (u_pred_taken & update_taken_in &
                                    (u_pred_target != update_target_in)));

   // A miss writes only when taken (allocation); a hit always trains.
   always_comb begin
      wr_en = update_valid_in && (u_hit || update_taken_in);
      ctr_d = u_hit ? ctr_sat_update(ctr_q[u_idx], update_taken_in) : CTR_WEAK_T;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         valid_q <= '0;
`ifdef BPU_RAS_EN
         ret_q   <= '0;
`endif
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WEAK_NT;
         end
      end else if (wr_en) begin
         valid_q[u_idx] <= 1'b1;
         tag_q[u_idx]   <= update_pc_in[PC-1:IDX+2];
         ctr_q[u_idx]   <= ctr_d;
         if (update_taken_in) begin
            target_q[u_idx] <= update_target_in;
         end
`ifdef BPU_RAS_EN
         ret_q[u_idx] <= update_is_ret_in;
`endif
      end
   end

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: stimulus queues expectations, a negedge monitor checks them.
// Return-stack scenarios are built only when BPU_RAS_EN is defined.
module tb_btb_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] fetch_pc;
   logic        fetch_pred;
   logic [31:0] pc_pred;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_call;
   logic        upd_ret;
   logic [1:0]  upd_conf;
   logic [31:0] pc_restore;
   logic        mispredict;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];

   localparam int SelPred = 0;
   localparam int SelPcp  = 1;
   localparam int SelConf = 2;
   localparam int SelRest = 3;
   localparam int SelMis  = 4;

   btb_predictor dut (
      .clk_in                (clk),
      .rst_in                (rst),
      .fetch_pc_in           (fetch_pc),
      .fetch_prediction_out  (fetch_pred),
      .pc_prediction_out     (pc_pred),
      .update_valid_in       (upd_valid),
      .update_pc_in          (upd_pc),
      .update_taken_in       (upd_taken),
      .update_target_in      (upd_target),
      .update_is_call_in     (upd_call),
      .update_is_ret_in      (upd_ret),
      .update_confidence_out (upd_conf),
      .pc_restore_out        (pc_restore),
      .mispredict_out        (mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: outputs are combinational, so every queued expectation is due at the next negedge.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         e = sb_q.pop_front();
         case (e.sel)
            SelPred: act = {31'd0, fetch_pred};
            SelPcp:  act = pc_pred;
            SelConf: act = {30'd0, upd_conf};
            SelRest: act = pc_restore;
            default: act = {31'd0, mispredict};
         endcase
         checks++;
         if (act !== e.exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
         end
      end
   end

   task automatic exp_push(input string n, input int sel, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.sel  = sel;
      e.exp  = v;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                        input logic tk, input logic [31:0] tgt, input logic call,
                        input logic ret);
      fetch_pc   = fpc;
      upd_valid  = uv;
      upd_pc     = upc;
      upd_taken  = tk;
      upd_target = tgt;
      upd_call   = call;
      upd_ret    = ret;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(32'h40, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
      repeat (2) step();
      rst = 1'b0;

      // Reset state
      exp_push("reset_pred", SelPred, 32'h0);
      exp_push("reset_pcp", SelPcp, 32'h44);
      exp_push("reset_conf", SelConf, 32'h0);
      exp_push("idle_mis", SelMis, 32'h0);
      exp_push("idle_restore", SelRest, 32'h80);
      step();

      // Same-cycle fetch and allocating update: fetch sees old contents
      drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
      exp_push("same_cyc_pred", SelPred, 32'h0);
      exp_push("same_cyc_pcp", SelPcp, 32'h44);
      exp_push("alloc_mis", SelMis, 32'h1);
      exp_push("alloc_conf", SelConf, 32'h0);
      step();
      drive(32'h40, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
      exp_push("after_alloc_pred", SelPred, 32'h1);
      exp_push("after_alloc_pcp", SelPcp, 32'h80);
      exp_push("after_alloc_conf", SelConf, 32'h2);
      step();

      // Counter up to saturation, target rewrite on taken
      drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
      exp_push("taken_hit_mis", SelMis, 32'h0);
      exp_push("taken_hit_conf", SelConf, 32'h2);
      step();
      drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h90, 1'b0, 1'b0);
      exp_push("sat_conf", SelConf, 32'h3);
      exp_push("tgt_diff_mis", SelMis, 32'h1);
      step();

      // Counter down to saturation
      drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h90, 1'b0, 1'b0);
      exp_push("new_tgt_pcp", SelPcp, 32'h90);
      exp_push("nt1_conf", SelConf, 32'h3);
      exp_push("nt1_mis", SelMis, 32'h1);
      exp_push("nt_restore", SelRest, 32'h44);
      step();
      drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h90, 1'b0, 1'b0);
      exp_push("nt2_conf", SelConf, 32'h2);
      exp_push("nt2_mis", SelMis, 32'h1);
      step();
      drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h90, 1'b0, 1'b0);
      exp_push("nt3_conf", SelConf, 32'h1);
      exp_push("nt3_mis", SelMis, 32'h0);
      exp_push("weak_nt_pred", SelPred, 32'h0);
      exp_push("weak_nt_pcp", SelPcp, 32'h44);
      step();
      drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h90, 1'b0, 1'b0);
      exp_push("nt4_conf", SelConf, 32'h0);
      exp_push("nt4_mis", SelMis, 32'h0);
      step();
      drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h90, 1'b0, 1'b0);
      exp_push("strong_nt_taken_mis", SelMis, 32'h1);
      step();
      drive(32'h40, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      exp_push("hit_train_conf", SelConf, 32'h1);
      exp_push("hit_train_pcp", SelPcp, 32'h44);
      step();

      // Aliasing tag at the same index replaces the victim
      drive(32'h40, 1'b1, 32'h440, 1'b1, 32'h500, 1'b0, 1'b0);
      exp_push("alias_conf", SelConf, 32'h0);
      exp_push("alias_mis", SelMis, 32'h1);
      step();
      drive(32'h440, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      exp_push("alias_new_pred", SelPred, 32'h1);
      exp_push("alias_new_pcp", SelPcp, 32'h500);
      exp_push("alias_old_conf", SelConf, 32'h0);
      step();
      drive(32'h40, 1'b0, 32'h440, 1'b0, 32'h0, 1'b0, 1'b0);
      exp_push("alias_old_pred", SelPred, 32'h0);
      exp_push("alias_old_pcp", SelPcp, 32'h44);
      exp_push("alias_new_conf", SelConf, 32'h2);
      step();

      // Not-taken miss writes nothing
      drive(32'h48, 1'b1, 32'h48, 1'b0, 32'h999, 1'b0, 1'b0);
      exp_push("nt_miss_mis", SelMis, 32'h0);
      exp_push("nt_miss_restore", SelRest, 32'h4c);
      step();
      drive(32'h48, 1'b0, 32'h48, 1'b0, 32'h0, 1'b0, 1'b0);
      exp_push("nt_miss_conf", SelConf, 32'h0);
      exp_push("nt_miss_pcp", SelPcp, 32'h4c);
      step();

      // Address wrap
      drive(32'hffff_fffc, 1'b0, 32'hffff_fffc, 1'b0, 32'h0, 1'b0, 1'b0);
      exp_push("wrap_pcp", SelPcp, 32'h0);
      exp_push("wrap_restore", SelRest, 32'h0);
      step();

      // Asynchronous reset during an in-flight update
      drive(32'h440, 1'b1, 32'h60, 1'b1, 32'h123, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      exp_push("in_reset_pred", SelPred, 32'h0);
      exp_push("in_reset_pcp", SelPcp, 32'h444);
      exp_push("in_reset_mis", SelMis, 32'h1);
      step();
      drive(32'h60, 1'b0, 32'h440, 1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
      exp_push("discard_pcp", SelPcp, 32'h64);
      exp_push("cleared_conf", SelConf, 32'h0);
      step();
      drive(32'h440, 1'b0, 32'h60, 1'b0, 32'h0, 1'b0, 1'b0);
      exp_push("cleared_pcp", SelPcp, 32'h444);
      exp_push("discard_conf", SelConf, 32'h0);
      step();

`ifdef BPU_RAS_EN
      begin
         logic [31:0] pop_exp [4];
         pop_exp[0] = 32'h414;
         pop_exp[1] = 32'h410;
         pop_exp[2] = 32'h40c;
         pop_exp[3] = 32'h999;

         // Ret entry trained with an empty stack keeps its stored target
         drive(32'h0, 1'b1, 32'h300, 1'b1, 32'h999, 1'b0, 1'b1);
         exp_push("ret_alloc_mis", SelMis, 32'h1);
         step();
         drive(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
         exp_push("ret_empty_pred", SelPred, 32'h1);
         exp_push("ret_empty_pcp", SelPcp, 32'h999);
         step();
         drive(32'h300, 1'b1, 32'h104, 1'b1, 32'h800, 1'b1, 1'b0);
         step();
         drive(32'h300, 1'b1, 32'h208, 1'b1, 32'h800, 1'b1, 1'b0);
         exp_push("ras_one_pcp", SelPcp, 32'h108);
         step();
         drive(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
         exp_push("ras_two_pcp", SelPcp, 32'h20c);
         step();
         drive(32'h300, 1'b1, 32'h310, 1'b1, 32'h20c, 1'b0, 1'b1);
         exp_push("pop1_mis", SelMis, 32'h1);
         step();
         drive(32'h300, 1'b1, 32'h310, 1'b1, 32'h108, 1'b0, 1'b1);
         exp_push("after_pop_pcp", SelPcp, 32'h108);
         exp_push("ras_ret_mis", SelMis, 32'h0);
         step();
         drive(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
         exp_push("ras_drained_pcp", SelPcp, 32'h999);
         step();

         // Five calls into a four-deep stack
         for (int i = 0; i < 5; i++) begin
            drive(32'h300, 1'b1, 32'h404 + 32'(4 * i), 1'b1, 32'h800, 1'b1, 1'b0);
            step();
         end
         drive(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
         exp_push("ovf_top_pcp", SelPcp, 32'h418);
         step();
         for (int i = 0; i < 4; i++) begin
            drive(32'h300, 1'b1, 32'h310, 1'b1, 32'h0, 1'b0, 1'b1);
            step();
            drive(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            exp_push($sformatf("ovf_pop%0d_pcp", i), SelPcp, pop_exp[i]);
            step();
         end
      end
`endif

      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
